// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port: port 0 (LSU) has fixed
// priority, port 1 (debug/DMA loader) is protected by a starvation counter and a bus lock.
module dmem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wData0,
   input  logic [2:0]  size0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wData1,
   input  logic [2:0]  size1,
   input  logic        lock1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rValid0,
   output logic        rValid1,
   output logic [31:0] rData,
   output logic [31:0] memAddr,
   output logic [31:0] memWData,
   output logic [2:0]  memSize,
   output logic        memWEn,
   output logic        memREn,
   input  logic [31:0] memRData
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 3;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_starve_cnt;
   logic             r_rvalid0;
   logic             r_rvalid1;

   logic             w_starved;
   logic             w_gnt0;
   logic             w_gnt1;

   // Grant decode; everything is forced low while reset is asserted.
   always_comb begin
      w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
      w_gnt0    = 1'b0;
      w_gnt1    = 1'b0;
      if (rstN) begin
         if (r_state == LOCKED) begin
            w_gnt1 = req1;
         end else begin
            w_gnt1 = req1 & (~req0 | w_starved);
            w_gnt0 = req0 & ~w_gnt1;
         end
      end
   end

   // Memory-side mux: the granted port's payload, or all zeros when idle.
   always_comb begin
      memAddr  = AW'(0);
      memWData = DW'(0);
      memSize  = SW'(0);
      memWEn   = 1'b0;
      memREn   = 1'b0;
      if (w_gnt0) begin
         memAddr  = addr0;
         memWData = wData0;
         memSize  = size0;
         memWEn   = we0;
         memREn   = ~we0;
      end else if (w_gnt1) begin
         memAddr  = addr1;
         memWData = wData1;
         memSize  = size1;
         memWEn   = we1;
         memREn   = ~we1;
      end
   end

   // Lock FSM, starvation counter and read-valid pipeline.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state      <= ARB;
         r_starve_cnt <= CNT_W'(0);
         r_rvalid0    <= 1'b0;
         r_rvalid1    <= 1'b0;
      end else begin
         case (r_state)
            ARB:     if (w_gnt1 && lock1) r_state <= LOCKED;
            LOCKED:  if (!req1 || (w_gnt1 && !lock1)) r_state <= ARB;
            default: r_state <= ARB;
         endcase

         if (w_gnt1 || !req1) begin
            r_starve_cnt <= CNT_W'(0);
         end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end

         r_rvalid0 <= w_gnt0 & ~we0;
         r_rvalid1 <= w_gnt1 & ~we1;
      end
   end

   assign gnt0    = w_gnt0;
   assign gnt1    = w_gnt1;
   assign rValid0 = r_rvalid0;
   assign rValid1 = r_rvalid1;
   assign rData   = memRData;

endmodule
